// File: rtl/pipe_pkg.sv
// Shared types for the handshaked pipeline stage: state encoding and occupancy width.
package pipe_pkg;

  localparam int unsigned PIPE_OCC_W = 2;

  typedef enum logic [PIPE_OCC_W-1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for pipe_stage: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Environment side: produces upstream beats and consumes downstream beats.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// Handshaked pipeline register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_ZERO_ON_FLUSH_EN to clear the data registers on reset and flush.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  pipe_stage_if.slave           bus,
  output logic [PIPE_OCC_W-1:0] occupancy
);

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic accept_c;
  logic pop_c;
  logic main_ld_c;
  logic main_from_skid_c;
  logic skid_ld_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign pop_c    = out_valid_q & bus.out_ready;

  // Next state and data-register load enables.
  always_comb begin
    state_d          = state_q;
    main_ld_c        = 1'b0;
    main_from_skid_c = 1'b0;
    skid_ld_c        = 1'b0;
    case (state_q)
      PS_EMPTY: begin
        if (accept_c) begin
          state_d   = PS_ONE;
          main_ld_c = 1'b1;
        end
      end
      PS_ONE: begin
        if (accept_c && !pop_c) begin
          state_d   = PS_TWO;
          skid_ld_c = 1'b1;
        end else if (accept_c && pop_c) begin
          main_ld_c = 1'b1;
        end else if (pop_c) begin
          state_d = PS_EMPTY;
        end
      end
      PS_TWO: begin
        if (pop_c) begin
          state_d          = PS_ONE;
          main_ld_c        = 1'b1;
          main_from_skid_c = 1'b1;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    if (flush) state_d = PS_EMPTY;
  end

  // Handshake flags are flopped alongside the state so neither depends on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PS_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != PS_TWO);
      out_valid_q <= (state_d != PS_EMPTY);
    end
  end

`ifdef PIPE_STAGE_ZERO_ON_FLUSH_EN
  // All-zero payload reads as a NOP downstream.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld_c) main_q <= main_from_skid_c ? skid_q : bus.in_data;
      if (skid_ld_c) skid_q <= bus.in_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (main_ld_c) main_q <= main_from_skid_c ? skid_q : bus.in_data;
    if (skid_ld_c) skid_q <= bus.in_data;
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign occupancy     = PIPE_OCC_W'(state_q);

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised, handshaked pipeline register that replaces the fixed-field stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries an opaque DATA_W-bit payload; the parent packs control and operand fields. Uses a valid/ready handshake with a 2-entry skid buffer so that in_ready is driven from a flop, not from out_ready. Synchronous flush squashes all held beats for branch/jump/hazard recovery.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- flush  in  1  squash all held beats; synchronous; ignored during reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; registered
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream beat present; registered
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  downstream payload; registered
- occupancy  out  2  held beats, 0..2

## Operation
- Accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register drives out_data; skid register holds the second beat.
- States (pipe_state_t): PS_EMPTY (occ 0), PS_ONE (main valid), PS_TWO (main and skid valid).
- PS_EMPTY: accept -> PS_ONE, main <= in_data.
- PS_ONE: accept & !pop -> PS_TWO, skid <= in_data; accept & pop -> PS_ONE, main <= in_data; !accept & pop -> PS_EMPTY; else hold.
- PS_TWO: in_ready = 0 (accept impossible); pop -> PS_ONE, main <= skid; else hold.
- out_valid = (state != PS_EMPTY); in_ready = (state != PS_TWO); occupancy = state encoding.
- flush (rst_n high): next state PS_EMPTY regardless of accept/pop. A beat accepted in the flush cycle is dropped. A pop in the flush cycle counts as delivered.
- Priority: rst_n low > flush > normal transitions.
- While out_valid & !out_ready, out_data is held bit-stable.
- Beats are delivered in order, with no duplication or loss except on flush.

## Timing
- Reset values after the rst_n-low edge: out_valid 0, in_ready 1, occupancy 0, state PS_EMPTY. out_data/skid per Configuration.
- Latency: a beat accepted at edge N into an empty stage is visible on out_data/out_valid after edge N; one cycle.
- Throughput: 1 beat/cycle sustained while out_ready stays high.
- Backpressure: out_ready low for k cycles from PS_ONE accepts exactly one more beat, then in_ready drops after the next edge.
- in_ready rises on the edge after the pop that leaves PS_TWO.
- If reset asserts mid-transfer, all held beats are lost. A handshake in the reset cycle is ignored.

## Configuration
- PIPE_STAGE_ZERO_ON_FLUSH_EN defined: reset and flush also clear main and skid to 0, so out_data = 0 whenever out_valid = 0 after reset or flush. This matches the legacy zeroing of stage registers, where decode treats all-zero as a NOP.
- Not defined: data registers have no reset or flush term and load only on accept. Only the valid state is cleared. out_data is don't-care while out_valid = 0.

## Structure
- Shared package pipe_pkg: typedef pipe_state_t (PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2) and localparam PIPE_OCC_W = 2.
- Flat single module; no sub-module. Multi-stage chains are built by the parent instantiating pipe_stage repeatedly.
- The state register is the only control state. Data registers are plain enabled flops.

## Test plan
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> out_valid 0, in_ready 1, occupancy 0. With the macro defined, out_data 0.
- Streaming: DATA_W=32, out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles starting one cycle after the first accept.
- Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA and 0xB accepted, in_ready 0, occupancy 2, out_data holds 0xA. Release out_ready -> 0xA, 0xB, then 0xC delivered in order.
- Simultaneous accept and pop in PS_ONE: hold 0x5, push 0x6 with out_ready=1 -> occupancy stays 1, out_data 0x6 next cycle.
- Flush in PS_TWO with in_valid=1 and out_ready=0 -> next cycle out_valid 0, in_ready 1, occupancy 0, and the flush-cycle input never appears.
- Reset mid-stream: occupancy 2, assert rst_n=0 for one edge -> state PS_EMPTY. The first beat after reset appears with 1-cycle latency.
